// File: rtl/player_ctrl.sv
// player_ctrl -- per-frame player position update engine.
//
// Between frames (after EOF, before the next SOF) the block walks the players
// in ascending index order, one per clock, decodes each player's active-low
// key nibble into a single-axis move and saturates the result into the
// configured screen box.
//
// Optional feature: define PLAYER_CTRL_ACCEL_EN to give every player a
// saturating 4-bit hold counter that doubles the step once the same move has
// been held for HOLD_FRAMES consecutive passes.
module player_ctrl #(
  parameter int NPLAYERS    = 2,
  parameter int W           = 11,
  parameter int STEP        = 1,
  parameter int XMIN        = 0,
  parameter int XMAX        = 799,
  parameter int YMIN        = 0,
  parameter int YMAX        = 599,
  parameter int X0          = 400,
  parameter int Y0          = 300,
  parameter int DX_INIT     = 64,
  parameter int HOLD_FRAMES = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  SOF,
  input  logic                  EOF,
  input  logic [4*NPLAYERS-1:0] key,
  output logic [W*NPLAYERS-1:0] center_x,
  output logic [W*NPLAYERS-1:0] center_y,
  output logic [NPLAYERS-1:0]   moving,
  output logic                  upd
);

  localparam int IW    = (NPLAYERS > 1) ? $clog2(NPLAYERS) : 1;
  localparam int STEP2 = 2 * STEP;

  // Bounds and steps pre-sized to the W+1 bit arithmetic width.
  localparam logic signed [W:0] XMIN_E  = XMIN[W:0];
  localparam logic signed [W:0] XMAX_E  = XMAX[W:0];
  localparam logic signed [W:0] YMIN_E  = YMIN[W:0];
  localparam logic signed [W:0] YMAX_E  = YMAX[W:0];
  localparam logic signed [W:0] STEP_E  = STEP[W:0];
  localparam logic signed [W:0] STEP2_E = STEP2[W:0];

  // Elaboration-time guard against configurations the datapath cannot hold.
  if (NPLAYERS < 1 || NPLAYERS > 8 || HOLD_FRAMES < 0 || HOLD_FRAMES > 15) begin : g_bad_params
    $error("player_ctrl: NPLAYERS must be 1..8 and HOLD_FRAMES 0..15");
  end

  typedef enum logic [1:0] {LOCKED, UPDATE, DONE} state_t;
  typedef enum logic [1:0] {DIR_XP, DIR_YP, DIR_YN, DIR_XN} dir_t;

  state_t                state, state_next;
  logic [IW-1:0]         idx, idx_next;
  logic                  last_player;
  logic                  proc_en;
  logic                  upd_next;

  logic signed [W-1:0]   pos_x [NPLAYERS];
  logic signed [W-1:0]   pos_y [NPLAYERS];

  logic [3:0]            cur_key;
  logic signed [W-1:0]   cur_x, cur_y;
  logic signed [W:0]     x_ext, y_ext, sum_x, sum_y;
  logic signed [W-1:0]   new_x, new_y;
  logic                  move_valid;
  dir_t                  move_dir;
  logic signed [W:0]     step_amt;

  assign last_player = (idx == IW'(NPLAYERS - 1));

  // Saturate a W+1 bit signed value into [lo, hi]; bounds always fit in W bits.
  function automatic logic signed [W-1:0] clamp(input logic signed [W:0] v,
                                               input logic signed [W:0] lo,
                                               input logic signed [W:0] hi);
    logic signed [W:0] r;
    if (v < lo)      r = lo;
    else if (v > hi) r = hi;
    else             r = v;
    return r[W-1:0];
  endfunction

  // State register: FSM state, player index and the registered upd pulse.
  // NOTE: clocked state uses non-blocking assignments so every register sees the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= LOCKED;
      idx   <= '0;
      upd   <= 1'b0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      upd   <= upd_next;
    end
  end

  // Next-state logic: EOF opens a pass, SOF closes it, the last player ends it.
  // NOTE: every combinational output gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    case (state)
      LOCKED: begin
        idx_next = '0;
        if (EOF) state_next = UPDATE;   // EOF wins over a simultaneous SOF
      end
      UPDATE: begin
        if (SOF) begin
          state_next = LOCKED;
          idx_next   = '0;
        end else if (last_player) begin
          state_next = DONE;
          idx_next   = '0;
        end else begin
          idx_next   = idx + 1'b1;
        end
      end
      DONE: begin
        idx_next = '0;
        if (SOF) state_next = LOCKED;   // EOF here is ignored: one pass per frame
      end
      default: begin
        state_next = LOCKED;
        idx_next   = '0;
      end
    endcase
  end

  // Output logic: which cycles write a player and when the pass-complete pulse fires.
  always_comb begin
    proc_en  = (state == UPDATE);
    upd_next = (state == UPDATE) && last_player && !SOF;
  end

  // Decode the current player's key nibble and compute its saturated new position.
  always_comb begin
    cur_key    = key[{idx, 2'b00} +: 4];
    cur_x      = pos_x[idx];
    cur_y      = pos_y[idx];
    x_ext      = {cur_x[W-1], cur_x};
    y_ext      = {cur_y[W-1], cur_y};
    move_valid = 1'b1;
    move_dir   = DIR_XP;
    case (cur_key)
      4'b1110: move_dir = DIR_XP;
      4'b1101: move_dir = DIR_YP;
      4'b1011: move_dir = DIR_YN;
      4'b0111: move_dir = DIR_XN;
      default: move_valid = 1'b0;
    endcase
    sum_x = x_ext;
    sum_y = y_ext;
    if (move_valid) begin
      case (move_dir)
        DIR_XP:  sum_x = x_ext + step_amt;
        DIR_YP:  sum_y = y_ext + step_amt;
        DIR_YN:  sum_y = y_ext - step_amt;
        default: sum_x = x_ext - step_amt;
      endcase
    end
    new_x = clamp(sum_x, XMIN_E, XMAX_E);
    new_y = clamp(sum_y, YMIN_E, YMAX_E);
  end

`ifdef PLAYER_CTRL_ACCEL_EN
  logic [3:0] hold_cnt [NPLAYERS];
  dir_t       last_dir [NPLAYERS];
  logic       same_move;

  // Step selection: double speed once the same move has been held long enough.
  always_comb begin
    same_move = move_valid && (hold_cnt[idx] != 4'd0) && (last_dir[idx] == move_dir);
    step_amt  = (same_move && (int'(hold_cnt[idx]) >= HOLD_FRAMES)) ? STEP2_E : STEP_E;
  end

  // Hold counters: count repeats of the same move, restart on a new one, clear on idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < NPLAYERS; p++) begin
        hold_cnt[p] <= 4'd0;
        last_dir[p] <= DIR_XP;
      end
    end else if (proc_en) begin
      if (!move_valid) begin
        hold_cnt[idx] <= 4'd0;
      end else begin
        if (same_move) hold_cnt[idx] <= (hold_cnt[idx] == 4'hf) ? 4'hf : hold_cnt[idx] + 4'd1;
        else           hold_cnt[idx] <= 4'd1;
        last_dir[idx] <= move_dir;
      end
    end
  end
`else
  assign step_amt = STEP_E;
`endif

  // Player registers: positions and moving flags, written only in the player's own cycle.
  // NOTE: the position arrays are reset because their start values are architectural, not scratch storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < NPLAYERS; p++) begin
        pos_x[p] <= W'(X0 + p * DX_INIT);
        pos_y[p] <= W'(Y0);
      end
      moving <= '0;
    end else if (proc_en) begin
      pos_x[idx]  <= new_x;
      pos_y[idx]  <= new_y;
      moving[idx] <= (new_x != cur_x) || (new_y != cur_y);
    end
  end

  // Pack the per-player coordinates onto the flat output buses.
  for (genvar g = 0; g < NPLAYERS; g++) begin : g_pack
    assign center_x[g*W +: W] = pos_x[g];
    assign center_y[g*W +: W] = pos_y[g];
  end

endmodule

// File: tb/tb_player_ctrl.sv
// tb_player_ctrl -- directed self-checking bench for player_ctrl (default
// parameters: two players, W=11). Expected values are hand-computed.
module tb_player_ctrl;

  localparam int NP = 2;
  localparam int W  = 11;

  logic              clk = 1'b0;
  logic              reset;
  logic              SOF;
  logic              EOF;
  logic [4*NP-1:0]   key;
  logic [W*NP-1:0]   center_x;
  logic [W*NP-1:0]   center_y;
  logic [NP-1:0]     moving;
  logic              upd;

  int checks   = 0;
  int failures = 0;
  int upd_seen;

  player_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .SOF      (SOF),
    .EOF      (EOF),
    .key      (key),
    .center_x (center_x),
    .center_y (center_y),
    .moving   (moving),
    .upd      (upd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic logic signed [31:0] px(input int p);
    logic signed [W-1:0] v;
    v = center_x[p*W +: W];
    return 32'(v);
  endfunction

  function automatic logic signed [31:0] py(input int p);
    logic signed [W-1:0] v;
    v = center_y[p*W +: W];
    return 32'(v);
  endfunction

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_eof();
    EOF = 1'b1;
    tick();
    EOF = 1'b0;
  endtask

  task automatic pulse_sof();
    SOF = 1'b1;
    tick();
    SOF = 1'b0;
  endtask

  // Run n ticks and count upd pulses seen.
  task automatic watch(input int n);
    upd_seen = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (upd === 1'b1) upd_seen++;
    end
  endtask

  // One full frame: SOF, EOF, then enough cycles for the pass to finish.
  task automatic do_frame();
    pulse_sof();
    pulse_eof();
    watch(3);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    SOF   = 1'b0;
    EOF   = 1'b0;
    key   = 8'hff;
    do_reset();

    // Reset state
    check("rst_x0", px(0), 400);
    check("rst_x1", px(1), 464);
    check("rst_y0", py(0), 300);
    check("rst_y1", py(1), 300);
    check("rst_moving", 32'(moving), 0);
    check("rst_upd", 32'(upd), 0);

    // First pass: P0 right, P1 idle
    key = 8'hfe;
    pulse_eof();                               // E0
    check("e0_x0_unchanged", px(0), 400);
    tick();                                    // E1: P0 updated
    check("e1_x0", px(0), 401);
    check("e1_moving0", 32'(moving[0]), 1);
    check("e1_upd_low", 32'(upd), 0);
    tick();                                    // E2: P1 updated, upd follows
    check("e2_upd", 32'(upd), 1);
    check("e2_moving1", 32'(moving[1]), 0);
    check("e2_x1", px(1), 464);
    tick();
    check("e3_upd_low", 32'(upd), 0);

    // Second EOF without SOF is ignored
    pulse_eof();
    watch(3);
    check("eof2_x0", px(0), 401);
    check("eof2_upd", upd_seen, 0);

    // SOF then EOF runs a new pass
    do_frame();
    check("frame_x0", px(0), 402);
    check("frame_upd", upd_seen, 1);

    // Other directions
    key = 8'hfd;
    do_frame();
    check("yp_y0", py(0), 301);
    check("yp_x0", px(0), 402);
    key = 8'hfb;
    do_frame();
    check("yn_y0", py(0), 300);
    key = 8'hf7;
    do_frame();
    check("xn_x0", px(0), 401);
    check("xn_moving0", 32'(moving[0]), 1);

    // Two keys low: no move
    key = 8'hfc;
    do_frame();
    check("multi_x0", px(0), 401);
    check("multi_y0", py(0), 300);
    check("multi_moving0", 32'(moving[0]), 0);
    check("multi_upd", upd_seen, 1);

    // EOF and SOF together in LOCKED: EOF wins
    pulse_sof();
    key = 8'hfe;
    SOF = 1'b1;
    EOF = 1'b1;
    tick();
    SOF = 1'b0;
    EOF = 1'b0;
    watch(3);
    check("both_x0", px(0), 402);
    check("both_upd", upd_seen, 1);

    // SOF sampled at E1: P0 completes, P1 skipped, no upd
    pulse_sof();
    key = 8'hee;
    pulse_eof();                               // E0
    SOF = 1'b1;
    tick();                                    // E1
    SOF = 1'b0;
    check("abort_x0", px(0), 403);
    check("abort_upd_e1", 32'(upd), 0);
    watch(3);
    check("abort_x1", px(1), 464);
    check("abort_upd", upd_seen, 0);

    // Reset in the middle of a pass wins
    key = 8'hfe;
    pulse_eof();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    watch(3);
    check("midrst_x0", px(0), 400);
    check("midrst_x1", px(1), 464);
    check("midrst_moving", 32'(moving), 0);
    check("midrst_upd", upd_seen, 0);

    // Drive P1 to the right edge, then push once more
    key = 8'hef;
    for (int f = 0; f < 400; f++) do_frame();
    check("sat_x1", px(1), 799);
    do_frame();
    check("sat_x1_hold", px(1), 799);
    check("sat_moving1", 32'(moving[1]), 0);
    check("sat_upd", upd_seen, 1);
    check("sat_x0", px(0), 400);

    // Ten frames of held right key on P0
    do_reset();
    key = 8'hfe;
    for (int f = 0; f < 10; f++) do_frame();
`ifdef PLAYER_CTRL_ACCEL_EN
    check("hold10_x0", px(0), 412);
`else
    check("hold10_x0", px(0), 410);
`endif
    check("hold10_x1", px(1), 464);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/player_ctrl.md
PLAYER_CTRL -- requirements
Module: player_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter NPLAYERS, default 2, SHALL set the number of players (1..8).
REQ-003 Parameter W, default 11, SHALL set the width of each signed coordinate.
REQ-004 Parameter STEP, default 1, SHALL set the pixels moved per frame.
REQ-005 Parameters XMIN=0, XMAX=799, YMIN=0, YMAX=599 SHALL set the inclusive position bounds.
REQ-006 Parameters X0=400, Y0=300, DX_INIT=64 SHALL set the reset position: player p at (X0+p*DX_INIT, Y0).
REQ-007 Parameter HOLD_FRAMES, default 8, SHALL set the hold threshold used by ACCEL_EN.
REQ-008 clk  in  1  system clock.
REQ-009 reset  in  1  synchronous, active-high reset.
REQ-010 SOF  in  1  start-of-frame pulse.
REQ-011 EOF  in  1  end-of-frame pulse.
REQ-012 key  in  4*NPLAYERS  active-low buttons; bits [4p+3:4p] belong to player p.
REQ-013 center_x  out  W*NPLAYERS  signed X coordinates, packed; player p in bits [Wp+W-1:Wp].
REQ-014 center_y  out  W*NPLAYERS  signed Y coordinates, packed the same way.
REQ-015 moving  out  NPLAYERS  bit p is 1 if player p's last update changed its position.
REQ-016 upd  out  1  one-cycle pulse when a complete update pass has finished.

Function
REQ-017 The FSM SHALL have three states: LOCKED, UPDATE and DONE.
- LOCKED→UPDATE on EOF.
- UPDATE→DONE after the player index reaches NPLAYERS-1.
- UPDATE→LOCKED on SOF.
- DONE→LOCKED on SOF.
REQ-018 When EOF and SOF are high in the same cycle in LOCKED, EOF SHALL win and the FSM SHALL enter UPDATE.
REQ-019 EOF received while in UPDATE or DONE SHALL be ignored, so at most one pass runs per frame.
REQ-020 UPDATE SHALL process one player per cycle in ascending index order.
- EOF sampled at edge E0 → player p's registers update at edge E(p+1).
REQ-021 Player p's key nibble SHALL be sampled in that player's own UPDATE cycle.
REQ-022 Key decoding (exactly one bit low):
- 1110 → x+step
- 1101 → y+step
- 1011 → y−step
- 0111 → x−step
- any other pattern → no move.
REQ-023 Arithmetic SHALL be done in W+1 bits, and the result SHALL saturate to [XMIN,XMAX] or [YMIN,YMAX].
REQ-024 moving[p] SHALL be written in player p's UPDATE cycle; it is 1 only if the coordinate value changed, so a clamped move gives 0.
REQ-025 upd SHALL be 1 for exactly the cycle after the edge that updates player NPLAYERS-1, and 0 at all other times.
REQ-026 On SOF during UPDATE, the player processed that cycle SHALL complete, the remaining players SHALL be skipped, and upd SHALL NOT pulse.
REQ-027 Outputs SHALL hold their values in LOCKED and DONE.

Reset
REQ-028 reset SHALL put the FSM in LOCKED and set player index=0, upd=0, moving=0.
REQ-029 reset SHALL load the positions of REQ-006 and clear all hold counters.
REQ-030 reset SHALL take priority over every other input in the same cycle, including in the middle of UPDATE.

Configuration
REQ-031 With macro PLAYER_CTRL_ACCEL_EN defined, each player SHALL have a saturating 4-bit hold counter.
- The counter increments when the player makes the same single-key move as in its previous pass.
- The counter is set to 1 when the move is different.
- The counter is cleared on no-move.
- step = 2*STEP when the counter is ≥ HOLD_FRAMES before increment; otherwise step = STEP.
REQ-032 Without PLAYER_CTRL_ACCEL_EN, step SHALL always be STEP and no hold counters SHALL exist.

Verification
REQ-033 Reset, NPLAYERS=2 → center_x={464,400}, center_y={300,300}, moving=0, upd=0.
REQ-034 Reset scenarios:
- key0=1110, EOF → P0 x=401 at E1, upd pulses after E2.
- Second EOF without SOF → no change.
- SOF then EOF → x=402.
REQ-035 P1 at x=799, key1=1110, EOF → x stays 799, moving[1]=0, upd still pulses.
REQ-036 Update scenarios:
- key0=1100, EOF → no move, moving[0]=0.
- EOF and SOF in the same cycle → update pass runs.
- SOF at E1 → P1 not updated, no upd pulse.
REQ-037 key0=1110 held for 10 frames, HOLD_FRAMES=8 → x=412 with ACCEL_EN defined, x=410 without it.
